tx_ctrl: RTL and testbench
==========================

# tx_ctrl

Transmitter power-up sequencer; the TX counterpart of the receiver controller. On a PU_TX request it powers up and calibrates the current reference (IREF), then the synthesizer (SYNT), then the power amplifier (PA), and raises RDY_TX when all three report ready. It powers down in reverse order (PA first) so the PA is never live on an uncalibrated synthesizer. A calibration that fails to finish within a bounded time drives the block to a latched fault.

## Interface
- SETTLE_CYC, 10: cycles each block is held powered, uncalibrated, before its CAL is raised (≥1).
- CAL_TIMEOUT, 64: maximum cycles a CAL may stay high waiting for its RDY (≥1).
- CNT_W, 8: shared counter width; must hold max(SETTLE_CYC, CAL_TIMEOUT).
- CLK  in  1  clock; all logic is posedge.
- RST  in  1  reset, asynchronous, active-high.
- PU_TX  in  1  power-up request, level, synchronous to CLK.
- RDY_IREF / RDY_SYNT / RDY_PA  in  1 each  ready flags from the sub-blocks, synchronous to CLK.
- PU_IREF / PU_SYNT / PU_PA  out  1 each  power-up enables.
- CAL_IREF / CAL_SYNT / CAL_PA  out  1 each  calibration strobes, held high while waiting.
- RDY_TX  out  1  transmitter ready.
- ERR_TX  out  1  calibration timeout fault, latched.

## Operation
- States: IDLE, BIAS_ST, CAL_BIAS, SYNT_ST, CAL_SYN, PA_ST, CAL_PA, ON, PD_PA, PD_SYNT, FAULT.
- IDLE: all outputs 0. PU_TX=1 → BIAS_ST.
- x_ST (BIAS/SYNT/PA): the block's PU and all earlier PUs high. The state lasts exactly SETTLE_CYC cycles, then moves to the matching CAL state.
- CAL state: the block's CAL high. Move to the next x_ST, or to ON after CAL_PA, on the edge that samples its RDY=1; CAL drops on that edge.
- Timeout: if RDY has not been sampled high by the end of the CAL_TIMEOUT-th cycle in the CAL state → FAULT.
- Only the pending block's RDY is sampled. RDY changes outside its CAL state are ignored, including drops while ON.
- ON: all PU=1, all CAL=0, RDY_TX=1.
- PU_TX=0 in any state from BIAS_ST to ON → PD_PA:
  - PD_PA: PU_PA=0, all CAL=0, RDY_TX=0.
  - PD_SYNT: PU_SYNT also 0.
  - IDLE: PU_IREF also 0.
  - A PU_TX re-assertion during PD_PA or PD_SYNT is ignored; the sequence completes to IDLE and restarts from there if PU_TX is still 1.
- FAULT: all PU/CAL=0, RDY_TX=0, ERR_TX=1. Held until PU_TX=0, then IDLE with ERR_TX=0.
- One shared counter:
  - Cleared on every state entry.
  - Counts up, saturating.
  - Compared with SETTLE_CYC-1 in x_ST states and with CAL_TIMEOUT-1 in CAL states.

## Timing
- Outputs are registered and decoded from the next state, so they change on the same edge as the state.
- No combinational path from any input to any output.
- RST asserted → state IDLE, counter 0, every output 0 immediately, with no clock edge required.
- RST release: the first edge with RST low evaluates IDLE normally.
- Latency from the edge sampling PU_TX=1 to RDY_TX=1 is 3·SETTLE_CYC plus the sum of the three CAL waits, where each CAL wait is measured in edges from CAL entry to the edge sampling RDY=1.
- Power-down: PU_PA and RDY_TX fall 1 edge after PU_TX=0 is sampled, PU_SYNT 2 edges after, PU_IREF 3 edges after.
- Simultaneous events:
  - RDY=1 on the same edge as timeout expiry counts as success.
  - PU_TX=0 takes priority over RDY and over timeout.

## Structure
- Shared package holds:
  - the state enum (4-bit encoding);
  - default constants TX_SETTLE_CYC=10 and TX_CAL_TIMEOUT=64.
- The receiver controller imports the same package for its own defaults.
- Single module; the three per-block steps are inline states, so no sub-module.
- The testbench reuses the existing IREF/SYNT behavioural models. It adds a PA model with a programmable RDY delay.

## Test plan
- Reset: RST=1 mid-ON with PU_TX=1 → all outputs 0 before the next edge; after release, sequence restarts from BIAS_ST.
- Nominal, with SETTLE_CYC=4, CAL_TIMEOUT=16, each RDY sampled high on the 3rd edge after its CAL rises, PU_TX sampled 1 at edge 0:
  - PU_IREF=1 at edge 0, CAL_IREF at edge 4.
  - PU_SYNT at edge 7, CAL_SYNT at edge 11.
  - PU_PA at edge 14, CAL_PA at edge 18.
  - RDY_TX=1 at edge 21.
- Timeout: as nominal but RDY_SYNT stuck 0 → CAL_SYNT high for exactly 16 cycles, then FAULT with ERR_TX=1 and all PU=0. PU_TX=0 → IDLE, ERR_TX=0.
- Power-down from ON: PU_TX=0 sampled at edge n → PU_PA=0 and RDY_TX=0 at edge n+1, PU_SYNT=0 at n+2, PU_IREF=0 at n+3.
- Abort in CAL_SYN:
  - PU_TX=0 → CAL_SYNT=0 and PD_PA on the next edge.
  - PU_TX=1 re-asserted during PD_SYNT → IDLE, then BIAS_ST one edge later.
- Late RDY drop: RDY_IREF forced 0 while ON → RDY_TX stays 1; RDY arriving together with the timeout edge → success, no FAULT.

Source files
------------

// File: rtl/tx_ctrl_pkg.sv
// Shared definitions for the TX power-up sequencer: state encoding, output bundle, defaults.
// Imported by tx_ctrl and by the receiver controller for its own defaults.
package tx_ctrl_pkg;

    localparam int TX_SETTLE_CYC  = 10;
    localparam int TX_CAL_TIMEOUT = 64;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_BIAS_ST  = 4'd1,
        S_CAL_BIAS = 4'd2,
        S_SYNT_ST  = 4'd3,
        S_CAL_SYN  = 4'd4,
        S_PA_ST    = 4'd5,
        S_CAL_PA   = 4'd6,
        S_ON       = 4'd7,
        S_PD_PA    = 4'd8,
        S_PD_SYNT  = 4'd9,
        S_FAULT    = 4'd10
    } tx_state_e;

    typedef struct packed {
        logic err_tx;
        logic rdy_tx;
        logic cal_pa;
        logic cal_synt;
        logic cal_iref;
        logic pu_pa;
        logic pu_synt;
        logic pu_iref;
    } tx_out_t;

    // Output pattern belonging to a state; applied to the state being entered.
    function automatic tx_out_t tx_decode(input tx_state_e s);
        tx_out_t o;
        o = '0;
        case (s)
            S_BIAS_ST:  o.pu_iref = 1'b1;
            S_CAL_BIAS: begin o.pu_iref = 1'b1; o.cal_iref = 1'b1; end
            S_SYNT_ST:  begin o.pu_iref = 1'b1; o.pu_synt = 1'b1; end
            S_CAL_SYN:  begin o.pu_iref = 1'b1; o.pu_synt = 1'b1; o.cal_synt = 1'b1; end
            S_PA_ST:    begin o.pu_iref = 1'b1; o.pu_synt = 1'b1; o.pu_pa = 1'b1; end
            S_CAL_PA:   begin o.pu_iref = 1'b1; o.pu_synt = 1'b1; o.pu_pa = 1'b1; o.cal_pa = 1'b1; end
            S_ON:       begin o.pu_iref = 1'b1; o.pu_synt = 1'b1; o.pu_pa = 1'b1; o.rdy_tx = 1'b1; end
            S_PD_PA:    begin o.pu_iref = 1'b1; o.pu_synt = 1'b1; end
            S_PD_SYNT:  o.pu_iref = 1'b1;
            S_FAULT:    o.err_tx = 1'b1;
            default:    o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/tx_ctrl.sv
// TX power-up sequencer: IREF -> SYNT -> PA with settle/calibrate steps, reverse-order power-down, latched CAL timeout.
// Outputs registered from next state (change on the same edge as the state); no input-to-output combinational path.
module tx_ctrl
    import tx_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC  = TX_SETTLE_CYC,
    parameter int CAL_TIMEOUT = TX_CAL_TIMEOUT,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pu_tx,
    input  logic rdy_iref,
    input  logic rdy_synt,
    input  logic rdy_pa,
    output logic pu_iref,
    output logic pu_synt,
    output logic pu_pa,
    output logic cal_iref,
    output logic cal_synt,
    output logic cal_pa,
    output logic rdy_tx,
    output logic err_tx
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CAL_LAST    = CNT_W'(CAL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    tx_out_t          out_q, out_d;

    logic settle_done;
    logic cal_expired;
    logic seq_active;

    always_comb begin
        settle_done = (cnt_q == SETTLE_LAST);
        cal_expired = (cnt_q == CAL_LAST);
        seq_active  = 1'b0;
        state_d     = state_q;

        case (state_q)
            S_IDLE:     if (pu_tx) state_d = S_BIAS_ST;
            S_BIAS_ST:  begin
                seq_active = 1'b1;
                if (settle_done) state_d = S_CAL_BIAS;
            end
            // RDY on the expiry edge still wins over the timeout.
            S_CAL_BIAS: begin
                seq_active = 1'b1;
                if (rdy_iref)         state_d = S_SYNT_ST;
                else if (cal_expired) state_d = S_FAULT;
            end
            S_SYNT_ST:  begin
                seq_active = 1'b1;
                if (settle_done) state_d = S_CAL_SYN;
            end
            S_CAL_SYN:  begin
                seq_active = 1'b1;
                if (rdy_synt)         state_d = S_PA_ST;
                else if (cal_expired) state_d = S_FAULT;
            end
            S_PA_ST:    begin
                seq_active = 1'b1;
                if (settle_done) state_d = S_CAL_PA;
            end
            S_CAL_PA:   begin
                seq_active = 1'b1;
                if (rdy_pa)           state_d = S_ON;
                else if (cal_expired) state_d = S_FAULT;
            end
            S_ON:       seq_active = 1'b1;
            S_PD_PA:    state_d = S_PD_SYNT;
            S_PD_SYNT:  state_d = S_IDLE;
            S_FAULT:    if (!pu_tx) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Dropping the request overrides any RDY or timeout outcome.
        if (seq_active && !pu_tx) state_d = S_PD_PA;

        if (state_d != state_q)     cnt_d = '0;
        else if (cnt_q == CNT_MAX)  cnt_d = cnt_q;
        else                        cnt_d = cnt_q + 1'b1;

        out_d = tx_decode(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign pu_iref  = out_q.pu_iref;
    assign pu_synt  = out_q.pu_synt;
    assign pu_pa    = out_q.pu_pa;
    assign cal_iref = out_q.cal_iref;
    assign cal_synt = out_q.cal_synt;
    assign cal_pa   = out_q.cal_pa;
    assign rdy_tx   = out_q.rdy_tx;
    assign err_tx   = out_q.err_tx;

endmodule

// File: tb/tb_tx_ctrl.sv
// Bench for tx_ctrl: sub-block RDY models with programmable delay, randomized request traffic,
// compared every cycle against a stage/timer reference model.
module tb_tx_ctrl;

    localparam int SETTLE = 4;
    localparam int TMO    = 16;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_ON   = 2;
    localparam int M_PD   = 3;
    localparam int M_FLT  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pu_tx = 1'b0;
    logic [2:0] rdy = 3'b000;
    logic       pu_iref, pu_synt, pu_pa, cal_iref, cal_synt, cal_pa, rdy_tx, err_tx;
    logic [7:0] dut_vec;

    assign dut_vec = {err_tx, rdy_tx, cal_pa, cal_synt, cal_iref, pu_pa, pu_synt, pu_iref};

    tx_ctrl #(.SETTLE_CYC(SETTLE), .CAL_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .pu_tx(pu_tx),
        .rdy_iref(rdy[0]), .rdy_synt(rdy[1]), .rdy_pa(rdy[2]),
        .pu_iref(pu_iref), .pu_synt(pu_synt), .pu_pa(pu_pa),
        .cal_iref(cal_iref), .cal_synt(cal_synt), .cal_pa(cal_pa),
        .rdy_tx(rdy_tx), .err_tx(err_tx)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which block is coming up, whether its CAL is pending, elapsed time in that phase.
    int m_mode, m_blk, m_t, m_pd;
    bit m_cal;

    task automatic m_reset();
        m_mode = M_IDLE; m_blk = 0; m_t = 0; m_pd = 0; m_cal = 1'b0;
    endtask

    task automatic m_step(input bit pu, input bit [2:0] r);
        case (m_mode)
            M_IDLE: if (pu) begin m_mode = M_UP; m_blk = 0; m_cal = 1'b0; m_t = 0; end
            M_UP: begin
                if (!pu) begin
                    m_mode = M_PD; m_pd = 2;
                end else if (!m_cal) begin
                    m_t++;
                    if (m_t == SETTLE) begin m_cal = 1'b1; m_t = 0; end
                end else begin
                    m_t++;
                    if (r[m_blk]) begin
                        if (m_blk == 2) m_mode = M_ON;
                        else begin m_blk++; m_cal = 1'b0; m_t = 0; end
                    end else if (m_t == TMO) begin
                        m_mode = M_FLT;
                    end
                end
            end
            M_ON:  if (!pu) begin m_mode = M_PD; m_pd = 2; end
            M_PD:  begin m_pd--; if (m_pd == 0) m_mode = M_IDLE; end
            M_FLT: if (!pu) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic [7:0] m_out();
        logic [7:0] o;
        bit up, on;
        up = (m_mode == M_UP);
        on = (m_mode == M_ON);
        o = '0;
        o[0] = up || on || (m_mode == M_PD);
        o[1] = (up && m_blk >= 1) || on || (m_mode == M_PD && m_pd == 2);
        o[2] = (up && m_blk == 2) || on;
        for (int k = 0; k < 3; k++) o[3+k] = up && m_cal && (m_blk == k);
        o[6] = on;
        o[7] = (m_mode == M_FLT);
        return o;
    endfunction

    // Sub-block models: RDY rises once CAL has been seen high for dly[k] edges.
    int         dly[3];
    int         ccnt[3];
    bit         noise   = 1'b0;
    bit         rnd_dly = 1'b0;
    int         ecnt;
    int         rise_edge[8];
    logic [7:0] prev = '0;

    task automatic tick();
        bit       pu_s, rst_s;
        bit [2:0] r_s;
        pu_s  = pu_tx;
        r_s   = rdy;
        rst_s = rst;
        @(posedge clk);
        if (rst_s) m_reset();
        else       m_step(pu_s, r_s);
        #1;
        check("cycle_outputs", {24'd0, dut_vec}, {24'd0, m_out()});
        for (int k = 0; k < 8; k++)
            if (dut_vec[k] && !prev[k] && rise_edge[k] < 0) rise_edge[k] = ecnt;
        for (int k = 0; k < 3; k++) begin
            if (dut_vec[3+k] && !prev[3+k] && rnd_dly) dly[k] = $urandom_range(1, TMO + 2);
            if (dut_vec[3+k]) ccnt[k]++;
            else              ccnt[k] = 0;
            if (dut_vec[3+k]) rdy[k] = (ccnt[k] >= dly[k]);
            else              rdy[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        prev = dut_vec;
        ecnt++;
    endtask

    task automatic wait_bit(input string tag, input int b, input bit v, input int budget);
        int n;
        n = 0;
        while (dut_vec[b] !== v && n < budget) begin
            tick();
            n++;
        end
        if (dut_vec[b] !== v) check({tag, "_timeout"}, {31'd0, dut_vec[b]}, {31'd0, v});
    endtask

    task automatic clear_rise();
        for (int k = 0; k < 8; k++) rise_edge[k] = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        m_reset();
        for (int k = 0; k < 3; k++) begin dly[k] = 3; ccnt[k] = 0; end
        clear_rise();
        ecnt = 0;

        #3;
        check("reset_outputs", {24'd0, dut_vec}, 32'd0);
        tick(); tick();
        #2 rst = 1'b0;
        tick();
        check("idle_after_reset", {24'd0, dut_vec}, 32'd0);

        // Nominal bring-up; edge 0 is the one that samples the request.
        pu_tx = 1'b1;
        clear_rise();
        ecnt = 0;
        wait_bit("nominal_on", 6, 1'b1, 200);
        check("rise_pu_iref",  rise_edge[0], 0);
        check("rise_cal_iref", rise_edge[3], 4);
        check("rise_pu_synt",  rise_edge[1], 7);
        check("rise_cal_synt", rise_edge[4], 11);
        check("rise_pu_pa",    rise_edge[2], 14);
        check("rise_cal_pa",   rise_edge[5], 18);
        check("latency_rdy_tx", rise_edge[6], 3 * SETTLE + dly[0] + dly[1] + dly[2]);

        // Sub-block RDY lines dropping or chattering while ON must not matter.
        noise = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        noise = 1'b0;
        rdy   = 3'b000;
        tick();
        check("on_ignores_rdy_drop", {31'd0, rdy_tx}, 32'd1);

        // Asynchronous reset mid-ON with the request still high.
        #3 rst = 1'b1;
        #1;
        check("async_reset_clears", {24'd0, dut_vec}, 32'd0);
        m_reset();
        tick();
        #2 rst = 1'b0;
        tick();
        check("restart_bias_st", {24'd0, dut_vec}, 32'h01);
        wait_bit("restart_on", 6, 1'b1, 200);

        // Reverse-order power-down.
        pu_tx = 1'b0;
        tick(); check("pd_step1", {24'd0, dut_vec}, 32'h03);
        tick(); check("pd_step2", {24'd0, dut_vec}, 32'h01);
        tick(); check("pd_step3", {24'd0, dut_vec}, 32'h00);

        // SYNT never reports ready: CAL_SYNT must hold exactly TMO cycles, then latched fault.
        dly[1] = 100000;
        pu_tx  = 1'b1;
        wait_bit("to_cal_synt", 4, 1'b1, 200);
        n = 0;
        while (dut_vec[4] === 1'b1 && n < 100) begin tick(); n++; end
        check("cal_synt_high_cycles", n, TMO);
        check("fault_outputs", {24'd0, dut_vec}, 32'h80);
        tick(); tick();
        check("fault_held", {31'd0, err_tx}, 32'd1);
        pu_tx = 1'b0;
        tick();
        check("fault_cleared", {24'd0, dut_vec}, 32'h00);

        // RDY arriving on the timeout edge counts as success for every block.
        for (int k = 0; k < 3; k++) dly[k] = TMO;
        pu_tx = 1'b1;
        wait_bit("coincident_on", 6, 1'b1, 300);
        check("coincident_no_err", {31'd0, err_tx}, 32'd0);
        pu_tx = 1'b0;
        tick(); tick(); tick();

        // Abort during SYNT calibration, re-request while powering down.
        dly[1] = 50;
        pu_tx  = 1'b1;
        wait_bit("abort_cal_synt", 4, 1'b1, 200);
        pu_tx = 1'b0;
        tick();
        check("abort_pd_pa", {24'd0, dut_vec}, 32'h03);
        pu_tx = 1'b1;
        tick(); check("abort_pd_synt", {24'd0, dut_vec}, 32'h01);
        tick(); check("abort_idle",    {24'd0, dut_vec}, 32'h00);
        tick(); check("abort_restart", {24'd0, dut_vec}, 32'h01);

        // Randomized traffic against the model.
        noise   = 1'b1;
        rnd_dly = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) pu_tx = ~pu_tx;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
